ss_sg_arb: RTL
==============

SS_SG_ARB -- requirements
Module: ss_sg_arb

Interface
REQ-001 Parameter TO_CYCLES, default 255: cycles without ack/err/rty before the watchdog fires; range 1..255; used only with SS_SG_ARB_TIMEOUT_EN.
REQ-002 wb_clk_i  in  1  clock; all registers rise-edge.
REQ-003 wb_rst_i  in  1  reset; asynchronous, active-high; clock wb_clk_i.
REQ-004 m0_cyc, m0_stb, m0_we, m0_cab  in  1 each  WB master 0 (source SG reader) control.
REQ-005 m0_sel  in  4; m0_adr, m0_dat_i, m0_dat64_i  in  32 each  master 0 select/address/write data.
REQ-006 m0_dat_o, m0_dat64_o  out  32 each; m0_ack, m0_err, m0_rty  out  1 each  master 0 response.
REQ-007 m1_*  same names, widths and directions as m0_*  master 1 (destination SG reader).
REQ-008 wbm_cyc, wbm_stb, wbm_we, wbm_cab  out  1 each; wbm_sel  out  4; wbm_adr, wbm_dat_i, wbm_dat64_i  out  32 each  shared bus request.
REQ-009 wbm_dat_o, wbm_dat64_o  in  32 each; wbm_ack, wbm_err, wbm_rty  in  1 each  shared bus response.
REQ-010 gnt  out  2  one-hot current owner, 2'b00 when idle.
REQ-011 arb_state  out  8  debug: {last_owner, 5'b0, state[1:0]}.

Function
REQ-012 States: IDLE(0), OWN0(1), OWN1(2), TOUT(3); state register reset to IDLE.
REQ-013 IDLE: m0_cyc only -> OWN0; m1_cyc only -> OWN1; both -> master other than last_owner; last_owner resets to 1, so m0 wins first tie.
REQ-014 Grant latency: request seen in IDLE at edge N -> gnt valid and wbm_cyc high after edge N+1; no combinational grant.
REQ-015 OWNx holds while mx_cyc=1, regardless of rty/err; stb deassertion within a cycle does not release.
REQ-016 OWNx with mx_cyc=0: next state OWNy if my_cyc=1, else IDLE; last_owner<=x; no idle bubble on handover.
REQ-017 Request mux combinational from owner: wbm_* = mx_*; wbm_cyc = mx_cyc & owned; wbm_stb = mx_stb & owned; all wbm_* 0 in IDLE/TOUT.
REQ-018 Response: wbm_dat_o/wbm_dat64_o broadcast to both masters; ack/err/rty routed only to owner, 0 to non-owner.
REQ-019 Simultaneous owner cyc drop and response: response still forwarded that cycle; handover per REQ-016.
REQ-020 Non-owner may hold cyc indefinitely; it sees no responses until granted.

Reset
REQ-021 wb_rst_i asserted (any time, including mid-burst): state=IDLE, gnt=0, wbm_cyc=wbm_stb=0, all m*_ack/err/rty=0 immediately, watchdog counter=0, last_owner=1.
REQ-022 First grant after reset release follows REQ-013/014; no residual ownership.

Configuration
REQ-023 Macro SS_SG_ARB_TIMEOUT_EN defined: 8-bit counter increments each cycle wbm_cyc&wbm_stb&~(ack|err|rty), clears on any response or owner change; on reaching TO_CYCLES owner receives one-cycle mx_err=1, state->TOUT, wbm_cyc forced 0; TOUT->IDLE once owner cyc=0.
REQ-024 Macro undefined: no counter, no TOUT entry, err pure pass-through; state encoding unchanged.

Structure
REQ-025 Shared package ss_pkg holds state encodings (ARB_IDLE..ARB_TOUT), master index constants, and the WB response tuple {ack,rty,err} encoding shared with the SG readers.
REQ-026 One sub-module, ss_rr_pick: 2-input round-robin picker (req[1:0], last -> pick), combinational.

Verification
REQ-027 m0_cyc=1 alone at cycle 5 -> gnt=01 and wbm_adr=m0_adr at cycle 6; 2 acks forwarded to m0 only.
REQ-028 m0,m1 cyc rise same cycle after reset -> m0 first; m0 drops cyc -> gnt=10 next cycle, no IDLE cycle.
REQ-029 Owner m1 gets rty, holds cyc -> gnt stays 10; m1 drops cyc with m0 idle -> IDLE, gnt=00.
REQ-030 wb_rst_i pulsed mid-burst of m0 (adr 0x1000) -> wbm_cyc=0 same cycle, gnt=00, m0_ack=0.
REQ-031 With SS_SG_ARB_TIMEOUT_EN, TO_CYCLES=4, slave silent -> m0_err=1 after 4 stalled cycles, TOUT until m0_cyc=0.
REQ-032 Without macro, slave silent 300 cycles -> no err, gnt held 01 throughout.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared definitions for the SG reader arbiter: FSM encoding, master indices
// and the WB response tuple also used by the SG readers.
package ss_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2,
        ARB_TOUT = 2'd3
    } arb_st_t;

    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    typedef struct packed {
        logic ack;
        logic rty;
        logic err;
    } wb_resp_t;

    function automatic logic resp_hit(input wb_resp_t r);
        return r.ack | r.rty | r.err;
    endfunction

endpackage

// File: rtl/ss_rr_pick.sv
// Two-input round-robin picker: on a tie the master that did not own last wins.
module ss_rr_pick
    import ss_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick
);

    always_comb begin
        pick = M0_IDX;
        if (req == 2'b11)
            pick = ~last;
        else if (req[1])
            pick = M1_IDX;
    end

endmodule

// File: rtl/ss_sg_arb.sv
// Wishbone arbiter sharing one bus between the source and destination SG readers.
// Optional watchdog enabled by defining SS_SG_ARB_TIMEOUT_EN.
module ss_sg_arb
    import ss_pkg::*;
#(
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic        m0_cab,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_dat_i,
    input  logic [31:0] m0_dat64_i,
    output logic [31:0] m0_dat_o,
    output logic [31:0] m0_dat64_o,
    output logic        m0_ack,
    output logic        m0_err,
    output logic        m0_rty,

    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic        m1_cab,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_dat_i,
    input  logic [31:0] m1_dat64_i,
    output logic [31:0] m1_dat_o,
    output logic [31:0] m1_dat64_o,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        m1_rty,

    output logic        wbm_cyc,
    output logic        wbm_stb,
    output logic        wbm_we,
    output logic        wbm_cab,
    output logic [3:0]  wbm_sel,
    output logic [31:0] wbm_adr,
    output logic [31:0] wbm_dat_i,
    output logic [31:0] wbm_dat64_i,
    input  logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat64_o,
    input  logic        wbm_ack,
    input  logic        wbm_err,
    input  logic        wbm_rty,

    output logic [1:0]  gnt,
    output logic [7:0]  arb_state
);

    // A limit of zero would fire on grant; treat it as one.
    localparam logic [7:0] TO_LIMIT = (TO_CYCLES == 0) ? 8'd1 : 8'(TO_CYCLES);

    arb_st_t  state;
    logic     last_owner;
    logic     own0, own1;
    logic     pick;
    logic     to_fire;
    wb_resp_t bus_resp;

    assign own0 = (state == ARB_OWN0);
    assign own1 = (state == ARB_OWN1);

    ss_rr_pick u_pick (
        .req  ({m1_cyc, m0_cyc}),
        .last (last_owner),
        .pick (pick)
    );

`ifdef SS_SG_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;
    assign to_fire = (own0 | own1) && (to_cnt == TO_LIMIT);
`else
    assign to_fire = (TO_LIMIT == 8'd0);
`endif

    always_comb begin
        wbm_cyc     = 1'b0;
        wbm_stb     = 1'b0;
        wbm_we      = 1'b0;
        wbm_cab     = 1'b0;
        wbm_sel     = 4'h0;
        wbm_adr     = 32'h0;
        wbm_dat_i   = 32'h0;
        wbm_dat64_i = 32'h0;
        if (own0) begin
            wbm_cyc     = m0_cyc;
            wbm_stb     = m0_stb;
            wbm_we      = m0_we;
            wbm_cab     = m0_cab;
            wbm_sel     = m0_sel;
            wbm_adr     = m0_adr;
            wbm_dat_i   = m0_dat_i;
            wbm_dat64_i = m0_dat64_i;
        end else if (own1) begin
            wbm_cyc     = m1_cyc;
            wbm_stb     = m1_stb;
            wbm_we      = m1_we;
            wbm_cab     = m1_cab;
            wbm_sel     = m1_sel;
            wbm_adr     = m1_adr;
            wbm_dat_i   = m1_dat_i;
            wbm_dat64_i = m1_dat64_i;
        end
    end

    // Watchdog error rides on the err line of the owner for exactly the firing cycle.
    assign bus_resp = '{ack: wbm_ack, rty: wbm_rty, err: wbm_err | to_fire};

    assign m0_dat_o   = wbm_dat_o;
    assign m1_dat_o   = wbm_dat_o;
    assign m0_dat64_o = wbm_dat64_o;
    assign m1_dat64_o = wbm_dat64_o;
    assign m0_ack     = own0 & bus_resp.ack;
    assign m0_rty     = own0 & bus_resp.rty;
    assign m0_err     = own0 & bus_resp.err;
    assign m1_ack     = own1 & bus_resp.ack;
    assign m1_rty     = own1 & bus_resp.rty;
    assign m1_err     = own1 & bus_resp.err;

    assign arb_state = {last_owner, 5'b0, state};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ARB_IDLE;
            last_owner <= M1_IDX;
            gnt        <= 2'b00;
`ifdef SS_SG_ARB_TIMEOUT_EN
            to_cnt     <= 8'd0;
`endif
        end else begin
`ifdef SS_SG_ARB_TIMEOUT_EN
            // wbm_cyc is low whenever ownership is about to change, so that clears too.
            if (!wbm_cyc || to_fire || resp_hit(bus_resp))
                to_cnt <= 8'd0;
            else if (wbm_stb)
                to_cnt <= to_cnt + 8'd1;
`endif
            case (state)
                ARB_IDLE: begin
                    if (m0_cyc || m1_cyc) begin
                        state <= pick ? ARB_OWN1 : ARB_OWN0;
                        gnt   <= pick ? 2'b10 : 2'b01;
                    end
                end
                ARB_OWN0: begin
                    if (to_fire) begin
                        state      <= ARB_TOUT;
                        gnt        <= 2'b00;
                        last_owner <= M0_IDX;
                    end else if (!m0_cyc) begin
                        last_owner <= M0_IDX;
                        state      <= m1_cyc ? ARB_OWN1 : ARB_IDLE;
                        gnt        <= m1_cyc ? 2'b10 : 2'b00;
                    end
                end
                ARB_OWN1: begin
                    if (to_fire) begin
                        state      <= ARB_TOUT;
                        gnt        <= 2'b00;
                        last_owner <= M1_IDX;
                    end else if (!m1_cyc) begin
                        last_owner <= M1_IDX;
                        state      <= m0_cyc ? ARB_OWN0 : ARB_IDLE;
                        gnt        <= m0_cyc ? 2'b01 : 2'b00;
                    end
                end
                default: begin
                    if (!(last_owner ? m1_cyc : m0_cyc))
                        state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
